bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 20 ++
 rtl/bus_mux2.sv | 43 ++++
 rtl/bus_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: state encodings,
// default hold limit and bus widths.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  localparam int HOLD_MAX_DEFAULT = 16;
  localparam int ADDR_W           = 16;
  localparam int DATA_W           = 32;

  // A hold limit of 1 still needs a 1-bit counter to hold the constant 0.
  function automatic int cnt_width(input int hold_max);
    return (hold_max > 1) ? $clog2(hold_max) : 1;
  endfunction

endpackage

// File: rtl/bus_mux2.sv
// 2:1 selector of write enable, address and write data driven by the
// one-hot grant pair; parks the bus at zero when no master owns it.
module bus_mux2
  import bus_arbiter_pkg::*;
(
  input  logic              sel0,
  input  logic              sel1,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_dout,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_dout,
  output logic              y_wr,
  output logic [ADDR_W-1:0] y_addr,
  output logic [DATA_W-1:0] y_dout
);

  // Select the owner's signals; a non-owner never reaches the outputs
  always_comb begin
    y_wr   = 1'b0;
    y_addr = {ADDR_W{1'b0}};
    y_dout = {DATA_W{1'b0}};
    case ({sel1, sel0})
      2'b01: begin
        y_wr   = a_wr;
        y_addr = a_addr;
        y_dout = a_dout;
      end
      2'b10: begin
        y_wr   = b_wr;
        y_addr = b_addr;
        y_dout = b_dout;
      end
      default: begin
        y_wr   = 1'b0;
        y_addr = {ADDR_W{1'b0}};
        y_dout = {DATA_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a bounded hold time under
// contention and a combinational output mux toward the slave decoder.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout
);

  localparam int               CNT_W     = cnt_width(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [CNT_W-1:0] hold_cnt_r;
  logic             last_owner_r;
  logic             hold_expired_s;

  assign hold_expired_s = (hold_cnt_r == HOLD_LAST);

  // Next-state arbitration; a tie from IDLE goes to the master that did not own the bus last
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt_s = last_owner_r ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_req) begin
          state_nxt_s = ST_GRANT0;
        end else if (m1_req) begin
          state_nxt_s = ST_GRANT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (!m0_req) begin
          state_nxt_s = m1_req ? ST_GRANT1 : ST_IDLE;
        end else if (m1_req && hold_expired_s) begin
          state_nxt_s = ST_GRANT1;
        end else begin
          state_nxt_s = ST_GRANT0;
        end
      end
      ST_GRANT1: begin
        if (!m1_req) begin
          state_nxt_s = m0_req ? ST_GRANT0 : ST_IDLE;
        end else if (m0_req && hold_expired_s) begin
          state_nxt_s = ST_GRANT0;
        end else begin
          state_nxt_s = ST_GRANT1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, saturating hold counter and last-owner bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= {CNT_W{1'b0}};
      last_owner_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
        hold_cnt_r <= {CNT_W{1'b0}};
      end else if (!hold_expired_s) begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      if ((state_r != ST_IDLE) && (state_nxt_s != state_r)) begin
        last_owner_r <= (state_r == ST_GRANT1);
      end else begin
        last_owner_r <= last_owner_r;
      end
    end
  end

  // Grants come straight from the state register, so they are glitch-free and one-hot
  assign m0_grant = (state_r == ST_GRANT0);
  assign m1_grant = (state_r == ST_GRANT1);

  // A dropped request is masked even while the grant is still held
  assign m_req = (m0_grant & m0_req) | (m1_grant & m1_req);

  bus_mux2 u_mux (
    .sel0   (m0_grant),
    .sel1   (m1_grant),
    .a_wr   (m0_wr),
    .a_addr (m0_addr),
    .a_dout (m0_dout),
    .b_wr   (m1_wr),
    .b_addr (m1_addr),
    .b_dout (m1_dout),
    .y_wr   (m_wr),
    .y_addr (m_addr),
    .y_dout (m_dout)
  );

endmodule
